// File: rtl/banco_reg_pkg.sv
// Shared constants for the register bank and the write-register select mux.
// Register index codes and the $sp reset value live here so both ends agree.
package banco_reg_pkg;

  localparam int DATA_W = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

  localparam logic [31:0] SP_RESET = 32'd227;

endpackage

// File: rtl/banco_reg_if.sv
// Register-bank bus: one write port and two read ports.
// The master drives the write and read indices; the slave returns registered read data.
interface banco_reg_if
  import banco_reg_pkg::*;
#(
  parameter int DATA_W = banco_reg_pkg::DATA_W
);

  logic              RegWrite;
  reg_idx_t          WriteReg;
  logic [DATA_W-1:0] WriteData;
  reg_idx_t          ReadReg1;
  reg_idx_t          ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    output ReadData1, ReadData2
  );

endinterface

// File: rtl/banco_reg_read_port_bypass.sv
// One read port: forces index 0 to zero, bypasses a same-cycle write to the
// read index, and registers the selected value as the operand latch.
module banco_reg_read_port_bypass
  import banco_reg_pkg::*;
#(
  parameter int DATA_W = banco_reg_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  reg_idx_t          wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  reg_idx_t          rd_idx,
  input  logic [DATA_W-1:0] stor_data,
  output logic [DATA_W-1:0] rd_data_p1
);

  logic [DATA_W-1:0] sel_p0;

  always_comb begin
    sel_p0 = stor_data;
    if (rd_idx == REG_ZERO) begin
      sel_p0 = '0;
    end else if (we && (wr_idx == rd_idx)) begin
      sel_p0 = wr_data;
    end
  end

  // p0 -> p1: operand latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_p1 <= '0;
    end else begin
      rd_data_p1 <= sel_p0;
    end
  end

endmodule

// File: rtl/banco_reg.sv
// 32 x DATA_W register bank of the multicycle MIPS datapath: register 0 reads
// as zero, $sp resets to SP_RESET, two registered read ports with write bypass.
module banco_reg #(
  parameter int                         DATA_W   = banco_reg_pkg::DATA_W,
  parameter logic [DATA_W-1:0]          SP_RESET = DATA_W'(banco_reg_pkg::SP_RESET)
) (
  input  logic        clk,
  input  logic        reset,
  banco_reg_if.slave  bus
);

  import banco_reg_pkg::*;

  // Index 0 has no storage; entries 1..31 are the real registers.
  logic [DATA_W-1:0] regs [1:31];
  logic [DATA_W-1:0] stor_rd1;
  logic [DATA_W-1:0] stor_rd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= (5'(i) == REG_SP) ? SP_RESET : '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (bus.RegWrite && (bus.WriteReg == 5'(i))) begin
          regs[i] <= bus.WriteData;
        end
      end
    end
  end

  always_comb begin
    stor_rd1 = '0;
    stor_rd2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (bus.ReadReg1 == 5'(i)) stor_rd1 = regs[i];
      if (bus.ReadReg2 == 5'(i)) stor_rd2 = regs[i];
    end
  end

  banco_reg_read_port_bypass #(.DATA_W(DATA_W)) u_port1 (
    .clk        (clk),
    .reset      (reset),
    .we         (bus.RegWrite),
    .wr_idx     (bus.WriteReg),
    .wr_data    (bus.WriteData),
    .rd_idx     (bus.ReadReg1),
    .stor_data  (stor_rd1),
    .rd_data_p1 (bus.ReadData1)
  );

  banco_reg_read_port_bypass #(.DATA_W(DATA_W)) u_port2 (
    .clk        (clk),
    .reset      (reset),
    .we         (bus.RegWrite),
    .wr_idx     (bus.WriteReg),
    .wr_data    (bus.WriteData),
    .rd_idx     (bus.ReadReg2),
    .stor_data  (stor_rd2),
    .rd_data_p1 (bus.ReadData2)
  );

endmodule

// File: tb/tb_banco_reg.sv
// Self-checking bench for banco_reg: directed vectors with literal expectations
// plus a per-cycle comparison against an array model of the register file.
module tb_banco_reg;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  banco_reg_if #(.DATA_W(32)) bus ();

  banco_reg #(.DATA_W(32), .SP_RESET(32'd227)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: register array plus the two expected output latches.
  logic [31:0] mem [32];
  logic [31:0] exp1 = '0;
  logic [31:0] exp2 = '0;

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.RegWrite && bus.WriteReg == idx) return bus.WriteData;
    return mem[idx];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] = (i == 29) ? 32'd227 : 32'd0;
      exp1 = '0;
      exp2 = '0;
    end else begin
      exp1 = model_read(bus.ReadReg1);
      exp2 = model_read(bus.ReadReg2);
      if (bus.RegWrite && bus.WriteReg != 5'd0) mem[bus.WriteReg] = bus.WriteData;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rd1", bus.ReadData1, exp1);
      check("model_rd2", bus.ReadData2, exp2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wi, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.RegWrite  = we;
    bus.WriteReg  = wi;
    bus.WriteData = wd;
    bus.ReadReg1  = r1;
    bus.ReadReg2  = r2;
  endtask

  initial begin
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #2 reset = 1'b1;
    #1 chk_en = 1'b1;

    // Reset held: outputs stay cleared.
    step();
    step();
    check("rst_rd1", bus.ReadData1, 32'd0);
    check("rst_rd2", bus.ReadData2, 32'd0);
    #2 reset = 1'b0;

    // Sweep all indices on both ports after reset.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
      step();
      check("sweep_rd1", bus.ReadData1, (i == 29) ? 32'd227 : 32'd0);
      check("sweep_rd2", bus.ReadData2, ((31 - i) == 29) ? 32'd227 : 32'd0);
    end

    // Plain write then read.
    drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd9);
    step();
    check("wr8_rd1", bus.ReadData1, 32'hDEADBEEF);
    check("wr9_rd2", bus.ReadData2, 32'd0);

    // Writes to register 0 vanish, including through the bypass.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step();
    check("zero_byp_rd1", bus.ReadData1, 32'd0);
    check("zero_byp_rd2", bus.ReadData2, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step();
    check("zero_rd1", bus.ReadData1, 32'd0);
    check("zero_rd2", bus.ReadData2, 32'd0);

    // Same-cycle bypass on both ports.
    drive(1'b1, 5'd31, 32'h12345678, 5'd31, 5'd31);
    step();
    check("byp31_rd1", bus.ReadData1, 32'h12345678);
    check("byp31_rd2", bus.ReadData2, 32'h12345678);
    drive(1'b0, 5'd31, 32'hAAAA5555, 5'd31, 5'd31);
    step();
    check("nowe_rd1", bus.ReadData1, 32'h12345678);
    check("nowe_rd2", bus.ReadData2, 32'h12345678);
    drive(1'b1, 5'd8, 32'h0BADF00D, 5'd8, 5'd31);
    step();
    check("byp8_rd1", bus.ReadData1, 32'h0BADF00D);
    check("old31_rd2", bus.ReadData2, 32'h12345678);

    // Asynchronous reset between edges while a write to $sp is pending.
    drive(1'b1, 5'd29, 32'h00000055, 5'd29, 5'd29);
    #2 reset = 1'b1;
    #1;
    check("async_rd1", bus.ReadData1, 32'd0);
    check("async_rd2", bus.ReadData2, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd8);
    step();
    check("sp_after_rst", bus.ReadData1, 32'd227);
    check("r8_after_rst", bus.ReadData2, 32'd0);

    // Back-to-back writes while trailing reads on port 1.
    for (int idx = 1; idx < 32; idx++) begin
      drive(1'b1, 5'(idx), 32'(idx * 3), 5'(idx - 1), 5'(idx));
      step();
      check("b2b_rd1", bus.ReadData1, 32'((idx - 1) * 3));
      check("b2b_rd2", bus.ReadData2, 32'(idx * 3));
    end
    drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd29);
    step();
    check("b2b_last_rd1", bus.ReadData1, 32'd93);
    check("b2b_sp_rd2", bus.ReadData2, 32'd87);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
